// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential integer square-root unit.
//
// Contents:
//   state_t    - control FSM states (IDLE, CALC, DONE)
//   MAX_RW     - largest root width the step function supports
//   rem_t      - working-remainder type at maximum width (MAX_RW+2 bits)
//   root_t     - partial-root type at maximum width (MAX_RW bits)
//   step_t     - {rem, root} result of one restoring iteration
//   sqrt_step  - one bit-serial restoring square-root iteration
//
// Callers zero-extend their narrower rem/root into rem_t/root_t and slice
// the result back down. The restoring invariant rem <= 2*root keeps every
// intermediate value inside the caller's own RW+2 bits, so the slicing is
// exact.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_RW = 32;

    typedef logic [MAX_RW+1:0] rem_t;
    typedef logic [MAX_RW-1:0] root_t;

    typedef struct packed {
        rem_t  rem;
        root_t root;
    } step_t;

    // One iteration: bring down the next operand bit pair, try to subtract
    // (root<<2)|1, and shift the outcome of that trial into the root.
    function automatic step_t sqrt_step(
        input rem_t       rem,
        input root_t      root,
        input logic [1:0] pair
    );
        logic [MAX_RW+3:0] acc;
        logic [MAX_RW+3:0] trial;
        logic              ge;
        step_t             res;

        // Both are computed at full MAX_RW+4 width so nothing is lost
        // before the comparison.
        acc   = {rem, pair};
        trial = {2'b00, root, 2'b01};
        ge    = (acc >= trial);

        res.rem  = ge ? rem_t'(acc - trial) : rem_t'(acc);
        res.root = {root[MAX_RW-2:0], ge};
        return res;
    endfunction

endpackage

// File: rtl/sqrt_seq_dp.sv
// Datapath of the sequential square-root unit.
//
// Holds the operand shifter, the working remainder / partial root
// registers and the registered result (root with optional rounding and
// saturation, floor remainder). Sequencing comes from the control FSM in
// sqrt_seq.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active-high; clears every register
//   load    in   latch dt_in / rnd_in, clear remainder and root
//   step    in   perform one restoring iteration
//   finish  in   compute and register dt / rem / sat
//   rnd_in  in   round-to-nearest select, captured on load
//   dt_in   in   WIDTH-bit operand, captured on load
//   dt      out  RW-bit root (rounded when selected), held until next finish
//   rem     out  RW+1-bit floor remainder, held until next finish
//   sat     out  rounding saturated, held until next finish
module sqrt_seq_dp
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic               rnd_in,
    input  logic [WIDTH-1:0]   dt_in,
    output logic [WIDTH/2-1:0] dt,
    output logic [WIDTH/2:0]   rem,
    output logic               sat
);

    localparam int RW = WIDTH / 2;

    logic [WIDTH-1:0] opnd;
    logic [RW+1:0]    rem_q;
    logic [RW-1:0]    root_q;
    logic             rnd_q;

    step_t            st;
    logic             unused_step;

    logic [RW:0]      root_inc;
    logic             round_up;
    logic [RW-1:0]    dt_next;
    logic             sat_next;

    // The step function works at maximum width; only the low RW+2 / RW bits
    // carry information, the rest are always zero.
    assign st          = sqrt_step(rem_t'(rem_q), root_t'(root_q), opnd[WIDTH-1:WIDTH-2]);
    assign unused_step = ^st;

    // Rounding: the true root lies above root+0.5 exactly when the floor
    // remainder exceeds the floor root. Rounding up past the RW-bit range
    // clamps to all ones and flags saturation.
    always_comb begin
        root_inc = {1'b0, root_q} + {{RW{1'b0}}, 1'b1};
        round_up = rnd_q && (rem_q > {2'b00, root_q});
        dt_next  = root_q;
        sat_next = 1'b0;
        if (round_up) begin
            if (root_inc[RW]) begin
                dt_next  = '1;
                sat_next = 1'b1;
            end else begin
                dt_next  = root_inc[RW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd   <= '0;
            rem_q  <= '0;
            root_q <= '0;
            rnd_q  <= 1'b0;
            dt     <= '0;
            rem    <= '0;
            sat    <= 1'b0;
        end else begin
            if (load) begin
                opnd   <= dt_in;
                rnd_q  <= rnd_in;
                rem_q  <= '0;
                root_q <= '0;
            end else if (step) begin
                opnd   <= {opnd[WIDTH-3:0], 2'b00};
                rem_q  <= st.rem[RW+1:0];
                root_q <= st.root[RW-1:0];
            end

            if (finish) begin
                dt  <= dt_next;
                // The floor remainder never exceeds 2*root, so RW+1 bits hold it.
                rem <= rem_q[RW:0];
                sat <= sat_next;
            end
        end
    end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential integer square root: floor(sqrt(x)) and x - floor(sqrt(x))^2
// for an unsigned WIDTH-bit operand, one root bit per clock, with optional
// round-to-nearest on the root.
//
// Handshake: start_i is accepted only in IDLE (and only when abort_i is
// low); busy_o is high from the cycle after acceptance through the DONE
// cycle, RW+2 cycles in all; done_o pulses for the single DONE cycle, RW+1
// rising edges after the accepting edge, with dt_o/rem_o/sat_o already
// valid. start_i while busy is dropped. abort_i in CALC returns to IDLE
// without done_o; in DONE it has no effect. Results hold until the next
// DONE.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_i    in   asynchronous reset, active-high
//   start_i  in   start request
//   abort_i  in   synchronous abort of an operation in progress
//   rnd_i    in   round-to-nearest select, sampled with start_i
//   dt_i     in   WIDTH-bit operand, sampled with start_i
//   busy_o   out  high in CALC and DONE
//   done_o   out  one-cycle completion pulse
//   dt_o     out  RW-bit root, registered
//   rem_o    out  RW+1-bit floor remainder, registered
//   sat_o    out  rounding saturated, registered
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               rnd_i,
    input  logic [WIDTH-1:0]   dt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH/2-1:0] dt_o,
    output logic [WIDTH/2:0]   rem_o,
    output logic               sat_o
);

    localparam int RW = WIDTH / 2;
    localparam int CW = $clog2(RW) + 1;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 2 * MAX_RW) begin : g_bad_width
        $error("sqrt_seq: WIDTH must be even, >= 4 and <= %0d", 2 * MAX_RW);
    end

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          finish;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CALC runs RW iteration cycles (cnt 0..RW-1) and one further cycle at
    // cnt == RW that registers the result on its way into DONE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (cnt == CW'(RW)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    step       = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign busy_o = (state == CALC) || (state == DONE);
    assign done_o = (state == DONE);

    sqrt_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst_i),
        .load   (load),
        .step   (step),
        .finish (finish),
        .rnd_in (rnd_i),
        .dt_in  (dt_i),
        .dt     (dt_o),
        .rem    (rem_o),
        .sat    (sat_o)
    );

endmodule

// File: tb/tb_sqrt_seq.sv
// Bench for sqrt_seq (WIDTH=16). The driver issues operations and pushes
// the expected {dt, rem, sat} into exp_q; a monitor pops and compares on
// every done_o. Directed vectors carry hand-computed results; the random
// sweep uses an independent brute-force square-root model.
module tb_sqrt_seq;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;
  localparam int EW    = 2 * RW + 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             abort_i;
  logic             rnd_i;
  logic [WIDTH-1:0] dt_i;
  logic             busy_o;
  logic             done_o;
  logic [RW-1:0]    dt_o;
  logic [RW:0]      rem_o;
  logic             sat_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  logic [EW-1:0] exp_q[$];

  sqrt_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .abort_i (abort_i),
    .rnd_i   (rnd_i),
    .dt_i    (dt_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .dt_o    (dt_o),
    .rem_o   (rem_o),
    .sat_o   (sat_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [EW-1:0] pack(input int d, input int r, input logic s);
    return {RW'(d), (RW + 1)'(r), s};
  endfunction

  // Brute-force reference: smallest root with (root+1)^2 > x.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x, input logic r);
    int unsigned root;
    int unsigned rem;
    int unsigned d;
    logic        s;
    root = 0;
    while ((root + 1) * (root + 1) <= 32'(x)) root++;
    rem = 32'(x) - root * root;
    d   = root;
    s   = 1'b0;
    if (r && rem > root) begin
      if (root + 1 == (1 << RW)) begin
        d = (1 << RW) - 1;
        s = 1'b1;
      end else begin
        d = root + 1;
      end
    end
    return pack(int'(d), int'(rem), s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      if (!busy_o) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  // Issue one operation, then follow it to its done pulse and check the
  // latency and the busy window. Returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic r,
                        input logic [EW-1:0] exp, input logic scramble);
    int lat;
    int bw;
    wait_idle();
    dt_i    = x;
    rnd_i   = r;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    exp_q.push_back(exp);
    if (scramble) begin
      dt_i  = WIDTH'($urandom_range(0, 65535));
      rnd_i = 1'($urandom_range(0, 1));
    end
    check("busy_rise", 32'(busy_o), 32'd1);
    lat = -1;
    bw  = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_o) bw++;
      if (done_o) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(RW + 1));
    check("busy_cycles", 32'(bw), 32'(RW + 2));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result", 32'({dt_o, rem_o, sat_o}), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst_i   = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    rnd_i   = 1'b0;
    dt_i    = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy_o, done_o, dt_o, rem_o, sat_o}), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(busy_o), 32'd0);

    // Basic and boundary operands, floor mode.
    run_op(16'd144,   1'b0, pack(12, 0, 1'b0),    1'b0);
    run_op(16'd0,     1'b0, pack(0, 0, 1'b0),     1'b0);
    run_op(16'd1,     1'b0, pack(1, 0, 1'b0),     1'b0);
    run_op(16'd65535, 1'b0, pack(255, 510, 1'b0), 1'b0);

    // Round-to-nearest, including saturation at the top of the range.
    run_op(16'd156,   1'b1, pack(12, 12, 1'b0),   1'b0);
    run_op(16'd157,   1'b1, pack(13, 13, 1'b0),   1'b0);
    run_op(16'd65535, 1'b1, pack(255, 510, 1'b1), 1'b0);

    // Start while busy is dropped: exactly one done, for x=100.
    wait_idle();
    d0      = done_cnt;
    dt_i    = 16'd100;
    rnd_i   = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    exp_q.push_back(pack(10, 0, 1'b0));
    repeat (3) @(negedge clk);
    dt_i    = 16'd9;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

    // Abort in CALC after three iterations: no done, outputs held.
    wait_idle();
    d0      = done_cnt;
    dt_i    = 16'd50;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy_low", 32'(busy_o), 32'd0);
    check("abort_hold", 32'({dt_o, rem_o, sat_o}), 32'(pack(10, 0, 1'b0)));
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Abort together with start in IDLE: stays idle.
    d0      = done_cnt;
    dt_i    = 16'd25;
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abort_start_idle", 32'(busy_o), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_start_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset in the middle of CALC: outputs clear at once, no done.
    d0      = done_cnt;
    dt_i    = 16'd200;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("midcalc_reset", 32'({busy_o, done_o, dt_o, rem_o, sat_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (12) @(negedge clk);
    check("reset_no_done", 32'(done_cnt - d0), 32'd0);

    // Back-to-back random sweep; operand/rnd scrambled after acceptance.
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] x;
      logic             r;
      x = WIDTH'($urandom_range(0, 65535));
      r = 1'($urandom_range(0, 1));
      run_op(x, r, model(x, r), 1'b1);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
